// File: rtl/mac_accumulator_if.sv
// Beat-in / result-out handshake bundle for mac_accumulator.
// Upstream and downstream logic use the master modport. The accumulator uses the slave modport.
interface mac_accumulator_if #(
   parameter int PROD_W = 16,
   parameter int ACC_W  = 24
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [PROD_W-1:0] product;
   logic                     in_last;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [ACC_W-1:0]  acc_out;
   logic [7:0]               out_count;
   logic                     out_overflow;

   modport master (
      output in_valid, product, in_last, out_ready,
      input  in_ready, out_valid, acc_out, out_count, out_overflow
   );

   modport slave (
      input  in_valid, product, in_last, out_ready,
      output in_ready, out_valid, acc_out, out_count, out_overflow
   );
endinterface

// File: rtl/mac_accumulator.sv
// Saturating multiply-accumulate back end. It sums a burst of signed products and
// publishes the total, the beat count and a sticky overflow flag in an output register.
module mac_accumulator #(
   parameter int PROD_W = 16,
   parameter int ACC_W  = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   mac_accumulator_if.slave   bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]              count_q, count_d;
   logic                    ovf_q, ovf_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
   logic [7:0]              out_count_q, out_count_d;
   logic                    out_ovf_q, out_ovf_d;

   logic                    in_ready;
   logic                    accept;
   logic                    burst_end;
   logic signed [ACC_W-1:0] acc_base;
   logic signed [ACC_W:0]   sum;
   logic signed [ACC_W-1:0] sum_sat;
   logic                    sum_ovf;
   logic [7:0]              count_inc;

   // The sum carries one guard bit, so disagreeing top bits mean the ACC_W range was exceeded.
   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
      if (s[ACC_W] != s[ACC_W-1])
         sat_acc = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         sat_acc = s[ACC_W-1:0];
   endfunction

   function automatic logic acc_overflowed(input logic signed [ACC_W:0] s);
      acc_overflowed = (s[ACC_W] != s[ACC_W-1]);
   endfunction

   assign in_ready  = rst_n && !clear && (!out_valid_q || bus.out_ready);
   assign accept    = bus.in_valid && in_ready;
   assign acc_base  = (state_q == RUN) ? acc_q : '0;
   assign sum       = {acc_base[ACC_W-1], acc_base}
                    + {{(ACC_W+1-PROD_W){bus.product[PROD_W-1]}}, bus.product};
   assign sum_sat   = sat_acc(sum);
   assign sum_ovf   = acc_overflowed(sum);
   assign count_inc = count_q + 8'd1;
   // The 255th beat closes the burst even without in_last, so the count never wraps.
   assign burst_end = accept && (bus.in_last || (count_inc == 8'd255));

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      out_acc_d   = out_acc_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;

      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (accept) begin
         if (burst_end) begin
            out_valid_d = 1'b1;
            out_acc_d   = sum_sat;
            out_count_d = count_inc;
            out_ovf_d   = ovf_q | sum_ovf;
            state_d     = IDLE;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
         end else begin
            state_d = RUN;
            acc_d   = sum_sat;
            count_d = count_inc;
            ovf_d   = ovf_q | sum_ovf;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_acc_q   <= out_acc_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid_q;
   assign bus.acc_out      = out_acc_q;
   assign bus.out_count    = out_count_q;
   assign bus.out_overflow = out_ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator. A 24-bit and a 16-bit accumulator share one stimulus stream.
// Each is checked against a burst-level model, and directed literal expectations pin that model.
module tb_mac_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n;
   logic               clear;
   logic               in_valid;
   logic               in_last;
   logic               out_ready;
   logic signed [15:0] product;

   mac_accumulator_if #(.PROD_W(16), .ACC_W(24)) if24();
   mac_accumulator_if #(.PROD_W(16), .ACC_W(16)) if16();

   assign if24.in_valid  = in_valid;
   assign if24.product   = product;
   assign if24.in_last   = in_last;
   assign if24.out_ready = out_ready;
   assign if16.in_valid  = in_valid;
   assign if16.product   = product;
   assign if16.in_last   = in_last;
   assign if16.out_ready = out_ready;

   mac_accumulator #(.PROD_W(16), .ACC_W(24)) dut24 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if24.slave)
   );
   mac_accumulator #(.PROD_W(16), .ACC_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if16.slave)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Burst-level model. Index 0 is the 24-bit accumulator and index 1 is the 16-bit one.
   longint m_sum [2] = '{0, 0};
   bit     m_ovf [2] = '{0, 0};
   int     m_cnt     = 0;
   bit     m_ov      = 0;
   longint m_oacc[2] = '{0, 0};
   bit     m_oovf[2] = '{0, 0};
   int     m_ocnt    = 0;
   bit     m_take;
   longint m_s;

   function automatic longint wmax(input int i);
      return (i == 0) ? 64'sd8388607 : 64'sd32767;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sum = '{0, 0}; m_ovf = '{0, 0}; m_cnt = 0; m_ov = 0;
         m_oacc = '{0, 0}; m_oovf = '{0, 0}; m_ocnt = 0;
      end else begin
         m_take = in_valid && !clear && (!m_ov || out_ready);
         if (out_ready) m_ov = 0;
         if (clear) begin
            m_sum = '{0, 0}; m_ovf = '{0, 0}; m_cnt = 0;
         end else if (m_take) begin
            m_cnt++;
            for (int i = 0; i < 2; i++) begin
               m_s = m_sum[i] + product;
               if (m_s > wmax(i)) begin
                  m_s = wmax(i); m_ovf[i] = 1;
               end else if (m_s < -wmax(i) - 1) begin
                  m_s = -wmax(i) - 1; m_ovf[i] = 1;
               end
               m_sum[i] = m_s;
            end
            if (in_last || m_cnt == 255) begin
               m_ov = 1;
               m_ocnt = m_cnt;
               for (int i = 0; i < 2; i++) begin
                  m_oacc[i] = m_sum[i]; m_oovf[i] = m_ovf[i];
                  m_sum[i] = 0; m_ovf[i] = 0;
               end
               m_cnt = 0;
            end
         end
      end
   end

   bit exp_ready;
   always @(negedge clk) begin
      exp_ready = rst_n && !clear && (!m_ov || out_ready);
      chk("in_ready24", if24.in_ready, exp_ready);
      chk("in_ready16", if16.in_ready, exp_ready);
      chk("out_valid24", if24.out_valid, m_ov);
      chk("out_valid16", if16.out_valid, m_ov);
      if (m_ov || !rst_n) begin
         chk("acc24", if24.acc_out, m_oacc[0]);
         chk("acc16", if16.acc_out, m_oacc[1]);
         chk("count24", if24.out_count, m_ocnt);
         chk("count16", if16.out_count, m_ocnt);
         chk("ovf24", if24.out_overflow, m_oovf[0]);
         chk("ovf16", if16.out_overflow, m_oovf[1]);
      end
   end

   typedef struct {
      longint a24;
      longint a16;
      int     cnt;
      bit     o24;
      bit     o16;
   } res_t;
   res_t resq[$];

   always @(negedge clk) begin
      if (rst_n && if24.out_valid && out_ready)
         resq.push_back('{a24: if24.acc_out, a16: if16.acc_out, cnt: int'(if24.out_count),
                          o24: if24.out_overflow, o16: if16.out_overflow});
   end

   task automatic beat(input logic signed [15:0] p, input bit last);
      int t;
      bit r;
      t = 0;
      in_valid = 1'b1; product = p; in_last = last;
      while (1) begin
         @(negedge clk);
         r = if24.in_ready;
         @(posedge clk);
         #1;
         t++;
         if (r) break;
         if (t >= 50) begin
            n_chk++;
            $display("FAIL beat_accept: got no acceptance in %0d cycles, expected one", t);
            break;
         end
      end
   endtask

   task automatic check_res(input string name, input longint e24, input longint e16,
                            input int ecnt, input bit eo24, input bit eo16);
      int   t;
      res_t r;
      t = 0;
      in_valid = 1'b0;
      while (resq.size() == 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (resq.size() == 0) begin
         n_chk++;
         $display("FAIL %s: got no result, expected one within 20 cycles", name);
      end else begin
         r = resq.pop_front();
         chk({name, "_acc24"}, r.a24, e24);
         chk({name, "_acc16"}, r.a16, e16);
         chk({name, "_count"}, r.cnt, ecnt);
         chk({name, "_ovf24"}, r.o24, eo24);
         chk({name, "_ovf16"}, r.o16, eo16);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      product = '0; out_ready = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", if24.in_ready, 0);
      chk("rst_out_valid", if24.out_valid, 0);
      chk("rst_acc", if24.acc_out, 0);
      chk("rst_count", if24.out_count, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", if24.in_ready, 1);
      @(posedge clk);
      #1;

      // Three-beat burst, result visible the cycle after the last beat
      beat(16'sd21, 0);
      beat(16'sd64, 0);
      beat(-16'sd240, 1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("t1_latency_valid", if24.out_valid, 1);
      @(posedge clk);
      #1;
      check_res("t1", -155, -155, 3, 0, 0);

      // Positive saturation in the narrow accumulator, then a fresh burst
      beat(16'sd16384, 0);
      beat(16'sd16384, 1);
      check_res("t2_sat", 32768, 32767, 2, 0, 1);
      beat(-16'sd7310, 1);
      check_res("t2_fresh", -7310, -7310, 1, 0, 0);

      // Backpressure: pending result blocks input until downstream takes it
      out_ready = 1'b0;
      beat(16'sd5, 1);
      in_valid = 1'b1; product = 16'sd7; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_bp_ready", if24.in_ready, 0);
         chk("t3_bp_valid", if24.out_valid, 1);
         chk("t3_bp_hold", if24.acc_out, 5);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("t3_release_ready", if24.in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_res("t3_first", 5, 5, 1, 0, 0);
      check_res("t3_second", 7, 7, 1, 0, 0);

      // Clear aborts a burst and drops the beat presented with it
      beat(16'sd1, 0);
      beat(16'sd1, 0);
      clear = 1'b1; product = 16'sd99; in_last = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      chk("t4_clear_ready", if24.in_ready, 0);
      @(posedge clk);
      #1;
      clear = 1'b0;
      beat(16'sd12, 1);
      check_res("t4_clear", 12, 12, 1, 0, 0);

      // 255-beat auto-last, then the tail burst
      for (int i = 0; i < 300; i++) beat(16'sd1, 0);
      beat(16'sd1, 1);
      check_res("t5_auto", 255, 255, 255, 0, 0);
      check_res("t5_tail", 46, 46, 46, 0, 0);

      // Reset mid-burst, then reset with a pending result
      beat(16'sd3, 0);
      beat(16'sd4, 0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_mid_ready", if24.in_ready, 0);
      chk("t6_mid_valid", if24.out_valid, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b0;
      beat(16'sd9, 1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("t6_pending_valid", if24.out_valid, 1);
      chk("t6_pending_acc", if24.acc_out, 9);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", if24.out_valid, 0);
      chk("t6_rst_acc24", if24.acc_out, 0);
      chk("t6_rst_acc16", if16.acc_out, 0);
      chk("t6_rst_count", if24.out_count, 0);
      chk("t6_rst_ready", if24.in_ready, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      beat(16'sd1, 1);
      check_res("t6_after", 1, 1, 1, 0, 0);
      chk("queue_empty", resq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
